// File: rtl/mux_rr_arbiter_pkg.sv
// mux_arb_pkg
//   Shared definitions for the round-robin mux arbiter slice:
//   - N_REQ / SEL_W   : requester count and select width
//   - arb_state_t     : arbiter FSM states (IDLE, GRANT, GAP)
//   - onehot_from_index : binary index -> one-hot grant vector
//   Optional feature macro used elsewhere in this slice: MUX_RR_ARBITER_PRIO0_EN
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  // Turns a requester index into the matching one-hot grant vector
  function automatic logic [N_REQ-1:0] onehot_from_index(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin search. Finds the first set request at or
//   after index (last_ptr+1), wrapping from N_REQ-1 back to 0.
//   Ports:
//     req      in  [N_REQ-1:0] request vector
//     last_ptr in  [SEL_W-1:0] index of the previous round-robin winner
//     pick     out [SEL_W-1:0] winning index (only meaningful when any_req)
//     any_req  out             at least one request is set
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any_req
);

  logic [SEL_W-1:0] start;
  logic [N_REQ-1:0] rotated;
  logic [SEL_W-1:0] offset;

  // Rotate so the search origin sits at bit 0, take the lowest set bit,
  // then add the origin back. SEL_W-bit arithmetic gives the wrap for free.
  always_comb begin
    start   = last_ptr + SEL_W'(1);
    rotated = '0;
    offset  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rotated[i] = req[start + SEL_W'(i)];
    end
    // Walk downward so the lowest set bit is the last one written
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = SEL_W'(i);
      end
    end
    pick    = start + offset;
    any_req = |req;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin owner scheduler for a shared 8:1 one-bit mux. Each owner
//   keeps the mux for at most HOLD_CYCLES cycles, then a one-cycle GAP and
//   a one-cycle IDLE arbitration separate it from the next owner, so the
//   mux select never moves while someone owns it.
//   Parameters:
//     HOLD_CYCLES  max consecutive ownership cycles (1..255)
//     CNT_W        hold counter width (HOLD_CYCLES-1 must fit)
//   Ports:
//     clk         in   rising-edge clock
//     reset       in   asynchronous active-high reset
//     req         in   [7:0] request vector
//     grant       out  [7:0] registered one-hot grant, zero when unowned
//     sel         out  [2:0] registered mux select (current/last owner)
//     busy        out  high while an owner holds the mux
//     owner_done  out  one-cycle pulse on the cycle after ownership ends
//   Optional feature: define MUX_RR_ARBITER_PRIO0_EN to make requester 0
//   win every IDLE arbitration it takes part in, without disturbing the
//   round-robin pointer used for requesters 1..7.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             owner_done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  arb_state_t       state;
  logic [SEL_W-1:0] last_ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [SEL_W-1:0] rr_idx;
  logic             any_req;
  logic [SEL_W-1:0] win_idx;
  logic [SEL_W-1:0] ptr_next;

  rr_pick u_rr_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .pick     (rr_idx),
    .any_req  (any_req)
  );

`ifdef MUX_RR_ARBITER_PRIO0_EN
  // Requester 0 jumps the queue but leaves the pointer alone, so the
  // rotation among the others resumes where it stopped.
  assign win_idx  = req[0] ? '0       : rr_idx;
  assign ptr_next = req[0] ? last_ptr : rr_idx;
`else
  assign win_idx  = rr_idx;
  assign ptr_next = rr_idx;
`endif

  // Single FSM with registered outputs. The exit from GRANT drops the grant
  // and raises owner_done on the same edge; GAP only clears the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_ptr   <= SEL_W'(N_REQ - 1);
      hold_cnt   <= '0;
      grant      <= '0;
      sel        <= '0;
      busy       <= 1'b0;
      owner_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          owner_done <= 1'b0;
          if (any_req) begin
            grant    <= onehot_from_index(win_idx);
            sel      <= win_idx;
            last_ptr <= ptr_next;
            hold_cnt <= HOLD_LOAD;
            busy     <= 1'b1;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Either the window is used up or the owner let go
          if (hold_cnt == '0 || !req[sel]) begin
            grant      <= '0;
            busy       <= 1'b0;
            owner_done <= 1'b1;
            state      <= ST_GAP;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          owner_done <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          grant      <= '0;
          busy       <= 1'b0;
          owner_done <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Drives two arbiters (HOLD_CYCLES=4 and HOLD_CYCLES=1) from the same
//   request stream and compares both against an ownership-level model.
//   Honours MUX_RR_ARBITER_PRIO0_EN in the model when defined.
module tb_mux_rr_arbiter;

  localparam int HOLD_A = 4;
  localparam int HOLD_B = 1;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] req   = 8'h00;

  logic [7:0] grant_a, grant_b;
  logic [2:0] sel_a, sel_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int tests = 0;
  int fails = 0;

  // Model state per instance: owner index (-1 = nobody), cycles owned so far,
  // dead cycles still to wait before arbitration, round-robin anchor,
  // last select driven, and the expected owner_done pulse.
  int holds [2] = '{HOLD_A, HOLD_B};
  int owner [2];
  int age   [2];
  int cool  [2];
  int last  [2];
  int lsel  [2];
  bit done  [2];

  mux_rr_arbiter #(.HOLD_CYCLES(HOLD_A), .CNT_W(8)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .grant      (grant_a),
    .sel        (sel_a),
    .busy       (busy_a),
    .owner_done (done_a)
  );

  mux_rr_arbiter #(.HOLD_CYCLES(HOLD_B), .CNT_W(8)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .grant      (grant_b),
    .sel        (sel_b),
    .busy       (busy_b),
    .owner_done (done_b)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      owner[m] = -1;
      age[m]   = 0;
      cool[m]  = 0;
      last[m]  = 7;
      lsel[m]  = 0;
      done[m]  = 1'b0;
    end
  endtask

  // One clock edge of ownership rules, using the request seen at that edge
  task automatic modelStep(input logic [7:0] r);
    bit found;
    int idx;
    for (int m = 0; m < 2; m++) begin
      done[m] = 1'b0;
      if (owner[m] >= 0) begin
        if (age[m] >= holds[m] || r[owner[m]] == 1'b0) begin
          owner[m] = -1;
          done[m]  = 1'b1;
          cool[m]  = 1;
        end else begin
          age[m]++;
        end
      end else if (cool[m] > 0) begin
        cool[m]--;
      end else if (r != 8'h00) begin
        found = 1'b0;
`ifdef MUX_RR_ARBITER_PRIO0_EN
        if (r[0]) begin
          owner[m] = 0;
          found    = 1'b1;
        end
`endif
        for (int k = 1; k <= 8; k++) begin
          idx = (last[m] + k) % 8;
          if (!found && r[idx]) begin
            found    = 1'b1;
            owner[m] = idx;
            last[m]  = idx;
          end
        end
        age[m]  = 1;
        lsel[m] = owner[m];
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] g;
    logic [2:0] s;
    logic       b, d;
    logic [7:0] exp_g;
    for (int m = 0; m < 2; m++) begin
      g = (m == 0) ? grant_a : grant_b;
      s = (m == 0) ? sel_a   : sel_b;
      b = (m == 0) ? busy_a  : busy_b;
      d = (m == 0) ? done_a  : done_b;
      exp_g = (owner[m] >= 0) ? (8'h01 << owner[m]) : 8'h00;
      checkVal($sformatf("%s.h%0d.grant", tag, holds[m]), g, exp_g);
      checkVal($sformatf("%s.h%0d.sel", tag, holds[m]), {5'b0, s}, 8'(lsel[m]));
      checkVal($sformatf("%s.h%0d.busy", tag, holds[m]), {7'b0, b}, {7'b0, owner[m] >= 0});
      checkVal($sformatf("%s.h%0d.done", tag, holds[m]), {7'b0, d}, {7'b0, done[m]});
      checkVal($sformatf("%s.h%0d.onehot0", tag, holds[m]), {7'b0, $onehot0(g)}, 8'h01);
      if (g != 8'h00) begin
        checkVal($sformatf("%s.h%0d.grant_sel", tag, holds[m]), g, 8'h01 << s);
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input string tag);
    req = r;
    @(posedge clk);
    modelStep(r);
    #1;
    checkOutput(tag);
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once
  task automatic resetPulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput(tag);
    checkVal({tag, ".grant_zero"}, grant_a, 8'h00);
    checkVal({tag, ".sel_zero"}, {5'b0, sel_a}, 8'h00);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] r;
    #1;
    resetPulse("reset");

    // Nobody requests: nothing moves
    repeat (10) applyStimulus(8'h00, "idle");

    // Everyone requests: full rotation and back to 0
    resetPulse("rst_all");
    repeat (58) applyStimulus(8'hFF, "all");

    // Short request from 5: owner releases early
    resetPulse("rst_r5");
    repeat (2) applyStimulus(8'h20, "r5");
    repeat (5) applyStimulus(8'h00, "r5_drop");

    // Owner 3, then 0 joins: no preemption, 0 is next after wrap
    resetPulse("rst_r3");
    applyStimulus(8'h08, "r3");
    repeat (12) applyStimulus(8'h09, "r3_r0");

    // Reset while 6 owns the mux, then 6 again right after release
    resetPulse("rst_r6");
    repeat (2) applyStimulus(8'h40, "r6");
    resetPulse("rst_mid");
    applyStimulus(8'h40, "r6_again");
    checkVal("r6_again.grant", grant_a, 8'h40);

    // Two contenders 0 and 1
    resetPulse("rst_01");
    repeat (30) applyStimulus(8'h03, "r01");

    // Random traffic with occasional sparse patterns and resets
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r = 8'h01 << $urandom_range(0, 7);
        2: r = 8'($urandom) & 8'($urandom);
        default: r = req;
      endcase
      applyStimulus(r, "rand");
      if ($urandom_range(0, 99) == 0) resetPulse("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
